// File: rtl/fft_out_serializer_if.sv
// -----------------------------------------------------------------------------
// fft_out_serializer_if
// Groups the frame-capture and sample-stream signals of fft_out_serializer.
//
// Handshake semantics:
//   Capture side: frame_valid is a one-cycle pulse. The frame is taken on a
//   rising edge only when frame_ready is also high. A pulse while
//   frame_ready is low is dropped and flagged on the sticky overflow output.
//   Stream side: a beat transfers on every rising edge where
//   out_valid && out_ready. Once out_valid is high, it stays high, and
//   out_r/out_i/out_idx/out_last stay stable, until that beat transfers.
//
// Modports:
//   slave  - the serializer (receives frames, drives the sample stream)
//   master - the environment (drives frames and out_ready)
//
// Signals:
//   frame_valid, in_bus       frame pulse and packed {imag, real} slots
//   frame_ready               a capture bank is free
//   out_valid, out_ready      sample stream handshake
//   out_r, out_i              real/imag of the current natural-order bin
//   out_idx, out_last         bin index, high with bin N-1
//   overflow                  sticky dropped-frame flag
// -----------------------------------------------------------------------------
interface fft_out_serializer_if #(
  parameter int DW   = 16,
  parameter int N    = 32,
  parameter int LOGN = 5
);
  logic                frame_valid;
  logic [N*2*DW-1:0]   in_bus;
  logic                frame_ready;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_r;
  logic [DW-1:0]       out_i;
  logic [LOGN-1:0]     out_idx;
  logic                out_last;
  logic                overflow;

  modport slave (
    input  frame_valid, in_bus, out_ready,
    output frame_ready, out_valid, out_r, out_i, out_idx, out_last, overflow
  );

  modport master (
    output frame_valid, in_bus, out_ready,
    input  frame_ready, out_valid, out_r, out_i, out_idx, out_last, overflow
  );
endinterface

// File: rtl/fft_out_serializer.sv
// -----------------------------------------------------------------------------
// fft_out_serializer
// Captures a complete 32-point FFT output frame in one cycle and streams it
// out one complex sample per beat in natural bin order. The butterfly array
// delivers bit-reversed order, so bin n is read from stored slot bitrev(n).
// There are two capture banks, so a new frame can land while the previous
// frame drains.
//
// Optional build macro: FFT_OUT_SCALE_EN
//   When it is defined, every output component is (x + 16) >>> 5, computed
//   at DW+1 bits with round-half-up and truncated to DW. This gives a
//   1/N-normalised spectrum. When it is undefined, samples pass unmodified.
//
// Ports:
//   clk_MAC    system clock, rising edge
//   rst        asynchronous active-low reset
//   bus        fft_out_serializer_if.slave (capture and stream signals)
//   dbg_state  current FSM state (IDLE=0, LOAD=1, STREAM=2)
// -----------------------------------------------------------------------------
module fft_out_serializer #(
  parameter int DW   = 16,
  parameter int N    = 32,
  parameter int LOGN = 5
) (
  input  logic                  clk_MAC,
  input  logic                  rst,
  fft_out_serializer_if.slave   bus,
  output logic [1:0]            dbg_state
);

  localparam int SW = 2 * DW;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

`ifdef FFT_OUT_SCALE_EN
  localparam logic [DW:0] ROUND_ADD = (DW + 1)'(1) << (LOGN - 1);
`endif

  // Frame storage. Each bank holds N slots of {imag, real} in arrival order.
  logic [1:0][N*SW-1:0] bank_q, bank_d;

  logic            wsel_q, wsel_d;
  logic            rsel_q, rsel_d;
  logic [1:0]      full_q, full_d;
  logic [1:0]      state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_r_q, out_r_d;
  logic [DW-1:0]   out_i_q, out_i_d;
  logic [LOGN-1:0] out_idx_q, out_idx_d;
  logic            overflow_q, overflow_d;

  logic            frame_ready;
  logic            capture;
  logic            accept;
  logic [LOGN-1:0] rd_n;
  logic [LOGN-1:0] rd_slot;
  logic [N*SW-1:0] rd_bank;
  logic [SW-1:0]   rd_word;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] x);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = x[LOGN-1-i];
    return r;
  endfunction

`ifdef FFT_OUT_SCALE_EN
  function automatic logic [DW-1:0] scale(input logic [DW-1:0] x);
    logic [DW:0] sum;
    logic [DW:0] shifted;
    sum     = {x[DW-1], x} + ROUND_ADD;
    shifted = $signed(sum) >>> LOGN;
    return shifted[DW-1:0];
  endfunction
`endif

  assign frame_ready = ~full_q[wsel_q];
  assign capture     = bus.frame_valid & frame_ready;
  assign accept      = out_valid_q & bus.out_ready;

  // The sample to register next is bin 0 from LOAD, or the following bin
  // during STREAM.
  always_comb begin
    rd_n    = (state_q == ST_LOAD) ? '0 : out_idx_q + LOGN'(1);
    rd_slot = bitrev(rd_n);
    rd_bank = bank_q[rsel_q];
    rd_word = rd_bank[int'(rd_slot)*SW +: SW];
  end

  always_comb begin
    bank_d      = bank_q;
    wsel_d      = wsel_q;
    rsel_d      = rsel_q;
    full_d      = full_q;
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    out_idx_d   = out_idx_q;
    overflow_d  = overflow_q | (bus.frame_valid & ~frame_ready);

    // Capture targets bank wsel. It cannot collide with the release below,
    // because capture needs that bank empty and release needs its bank full.
    if (capture) begin
      bank_d[wsel_q] = bus.in_bus;
      full_d[wsel_q] = 1'b1;
      wsel_d         = ~wsel_q;
    end

    case (state_q)
      ST_IDLE: begin
        out_valid_d = 1'b0;
        if (full_q[rsel_q]) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        out_idx_d   = '0;
        out_valid_d = 1'b1;
        state_d     = ST_STREAM;
`ifdef FFT_OUT_SCALE_EN
        out_r_d     = scale(rd_word[DW-1:0]);
        out_i_d     = scale(rd_word[SW-1:DW]);
`else
        out_r_d     = rd_word[DW-1:0];
        out_i_d     = rd_word[SW-1:DW];
`endif
      end
      ST_STREAM: begin
        if (accept) begin
          if (out_idx_q != LAST_IDX) begin
            out_idx_d = rd_n;
`ifdef FFT_OUT_SCALE_EN
            out_r_d   = scale(rd_word[DW-1:0]);
            out_i_d   = scale(rd_word[SW-1:DW]);
`else
            out_r_d   = rd_word[DW-1:0];
            out_i_d   = rd_word[SW-1:DW];
`endif
          end else begin
            // Last bin is gone: free this bank and move on to the other one.
            full_d[rsel_q] = 1'b0;
            rsel_d         = ~rsel_q;
            out_valid_d    = 1'b0;
            state_d        = full_q[~rsel_q] ? ST_LOAD : ST_IDLE;
          end
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_MAC or negedge rst) begin
    if (!rst) begin
      wsel_q      <= 1'b0;
      rsel_q      <= 1'b0;
      full_q      <= 2'b00;
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_idx_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wsel_q      <= wsel_d;
      rsel_q      <= rsel_d;
      full_q      <= full_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      out_idx_q   <= out_idx_d;
      overflow_q  <= overflow_d;
    end
  end

  // Bank contents need no reset. Clearing the full flags already discards
  // them.
  always_ff @(posedge clk_MAC) begin
    bank_q <= bank_d;
  end

  assign bus.frame_ready = frame_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_r       = out_r_q;
  assign bus.out_i       = out_i_q;
  assign bus.out_idx     = out_idx_q;
  assign bus.out_last    = out_valid_q & (out_idx_q == LAST_IDX);
  assign bus.overflow    = overflow_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_fft_out_serializer.sv
// -----------------------------------------------------------------------------
// tb_fft_out_serializer
// Directed bench for fft_out_serializer. It covers reset, bin reordering and
// latency, backpressure, double buffering, overflow, and reset in the middle
// of a frame. A bit-reverse model fills an expected-beat queue that every
// accepted beat is checked against. A table of hand-computed bins is checked
// against the beats captured from one frame.
// -----------------------------------------------------------------------------
module tb_fft_out_serializer;

  localparam int DW   = 16;
  localparam int N    = 32;
  localparam int LOGN = 5;
  localparam int EW   = LOGN + 2 * DW;

  // clock / reset
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_out_serializer_if #(.DW(DW), .N(N), .LOGN(LOGN)) bus_if ();

  fft_out_serializer #(.DW(DW), .N(N), .LOGN(LOGN)) dut (
    .clk_MAC   (clk),
    .rst       (rst),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  // checking bookkeeping
  int n_checks;
  int n_pass;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // model
  function automatic logic [LOGN-1:0] tb_bitrev(input int n);
    logic [LOGN-1:0] v;
    logic [LOGN-1:0] r;
    v = LOGN'(n);
    for (int i = 0; i < LOGN; i++) r[LOGN-1-i] = v[i];
    return r;
  endfunction

  function automatic logic [DW-1:0] model_out(input logic [DW-1:0] x);
`ifdef FFT_OUT_SCALE_EN
    int s;
    s = ($signed(x) + 16) >>> 5;
    return DW'(s);
`else
    return x;
`endif
  endfunction

  function automatic logic [N*2*DW-1:0] mk_frame(input int base);
    logic [N*2*DW-1:0] f;
    for (int k = 0; k < N; k++)
      f[k*2*DW +: 2*DW] = {DW'(-(base + 5 * k)), DW'(base + 3 * k)};
    return f;
  endfunction

  // scoreboard
  logic [EW-1:0] exp_q[$];

  task automatic push_expected(input logic [N*2*DW-1:0] fr);
    logic [2*DW-1:0] w;
    for (int n = 0; n < N; n++) begin
      w = fr[int'(tb_bitrev(n))*2*DW +: 2*DW];
      exp_q.push_back({LOGN'(n), model_out(w[DW-1:0]), model_out(w[2*DW-1:DW])});
    end
  endtask

  // monitor: accepted beats, stall stability, per-bin capture
  int              beat_cnt;
  int              beat_t[128];
  logic [DW-1:0]   got_r[N];
  logic [DW-1:0]   got_i[N];
  logic            got_last[N];
  logic            stall_prev;
  logic [EW:0]     held;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", bus_if.out_valid, 1'b1);
        check("stall_stable", {bus_if.out_idx, bus_if.out_r, bus_if.out_i, bus_if.out_last}, held);
      end
      stall_prev = bus_if.out_valid && !bus_if.out_ready;
      held = {bus_if.out_idx, bus_if.out_r, bus_if.out_i, bus_if.out_last};
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", {bus_if.out_idx, bus_if.out_r, bus_if.out_i}, e);
          check("beat_last", bus_if.out_last, (e[EW-1:2*DW] == LOGN'(N - 1)));
          got_r[bus_if.out_idx]    = bus_if.out_r;
          got_i[bus_if.out_idx]    = bus_if.out_i;
          got_last[bus_if.out_idx] = bus_if.out_last;
          if (beat_cnt < 128) beat_t[beat_cnt] = cyc;
          beat_cnt++;
        end
      end
    end
  end

  // driver tasks
  task automatic send_frame(input logic [N*2*DW-1:0] fr, input logic exp_accept, input string nm);
    @(posedge clk); #1;
    check({nm, "_frame_ready"}, bus_if.frame_ready, exp_accept);
    bus_if.frame_valid = 1'b1;
    bus_if.in_bus      = fr;
    if (exp_accept) push_expected(fr);
    @(posedge clk); #1;
    bus_if.frame_valid = 1'b0;
  endtask

  task automatic wait_drain(input logic rnd_ready, input int budget, input string nm);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk); #1;
      if (rnd_ready) bus_if.out_ready = 1'($urandom_range(0, 1));
      k++;
    end
    check({nm, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    bus_if.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // table of hand-computed bins
  typedef struct {
    logic [LOGN-1:0] bin;
    logic [DW-1:0]   exp_r;
    logic [DW-1:0]   exp_i;
    logic            exp_last;
  } vec_t;

  vec_t              tbl[7];
  logic [N*2*DW-1:0] tbl_frame;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    beat_cnt = 0;
    stall_prev = 1'b0;
    rst = 1'b0;
    bus_if.frame_valid = 1'b0;
    bus_if.in_bus      = '0;
    bus_if.out_ready   = 1'b0;

`ifdef FFT_OUT_SCALE_EN
    tbl_frame = '0;
    tbl_frame[0*32 +: 32] = {16'd31, 16'd31};
    tbl_frame[1*32 +: 32] = {16'd32, 16'd32};
    tbl_frame[2*32 +: 32] = {16'd48, 16'd48};
    tbl_frame[3*32 +: 32] = {16'hFFD0, 16'hFFD0};
    tbl_frame[4*32 +: 32] = {16'h7FFF, 16'h7FFF};
    tbl[0] = '{5'd0,  16'd1,      16'd1,      1'b0};
    tbl[1] = '{5'd16, 16'd1,      16'd1,      1'b0};
    tbl[2] = '{5'd8,  16'd2,      16'd2,      1'b0};
    tbl[3] = '{5'd24, 16'hFFFF,   16'hFFFF,   1'b0};
    tbl[4] = '{5'd4,  16'h0400,   16'h0400,   1'b0};
    tbl[5] = '{5'd1,  16'd0,      16'd0,      1'b0};
    tbl[6] = '{5'd31, 16'd0,      16'd0,      1'b1};
`else
    for (int k = 0; k < N; k++) tbl_frame[k*32 +: 32] = {16'(-k), 16'(k)};
    tbl[0] = '{5'd0,  16'd0,  16'd0,    1'b0};
    tbl[1] = '{5'd1,  16'd16, 16'hFFF0, 1'b0};
    tbl[2] = '{5'd2,  16'd8,  16'hFFF8, 1'b0};
    tbl[3] = '{5'd3,  16'd24, 16'hFFE8, 1'b0};
    tbl[4] = '{5'd5,  16'd20, 16'hFFEC, 1'b0};
    tbl[5] = '{5'd30, 16'd15, 16'hFFF1, 1'b0};
    tbl[6] = '{5'd31, 16'd31, 16'hFFE1, 1'b1};
`endif

    // reset held, frame pulses must be ignored
    repeat (3) begin
      @(posedge clk); #1;
      bus_if.frame_valid = 1'b1;
      bus_if.in_bus      = mk_frame(500);
      @(posedge clk); #1;
      bus_if.frame_valid = 1'b0;
    end
    @(negedge clk);
    check("rst_out_valid",   bus_if.out_valid,   1'b0);
    check("rst_out_last",    bus_if.out_last,    1'b0);
    check("rst_out_idx",     bus_if.out_idx,     0);
    check("rst_out_r",       bus_if.out_r,       0);
    check("rst_out_i",       bus_if.out_i,       0);
    check("rst_overflow",    bus_if.overflow,    1'b0);
    check("rst_frame_ready", bus_if.frame_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("post_rst_frame_ready", bus_if.frame_ready, 1'b1);
    check("post_rst_out_valid",   bus_if.out_valid,   1'b0);
    check("post_rst_state_idle",  dbg_state,          2'd0);

    // table frame: reordering and capture-to-valid latency
    bus_if.out_ready = 1'b1;
    beat_cnt = 0;
    send_frame(tbl_frame, 1'b1, "tbl");
    @(negedge clk);
    check("lat_edge1_valid", bus_if.out_valid, 1'b0);
    @(negedge clk);
    check("lat_edge2_valid", bus_if.out_valid, 1'b0);
    @(negedge clk);
    check("lat_valid_up", bus_if.out_valid, 1'b1);
    wait_drain(1'b0, 200, "tbl");
    check("tbl_beats", beat_cnt, 32);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("tbl%0d_r", i),    got_r[tbl[i].bin],    tbl[i].exp_r);
      check($sformatf("tbl%0d_i", i),    got_i[tbl[i].bin],    tbl[i].exp_i);
      check($sformatf("tbl%0d_last", i), got_last[tbl[i].bin], tbl[i].exp_last);
    end

    // backpressure with a pseudo-random out_ready
    beat_cnt = 0;
    bus_if.out_ready = 1'b0;
    send_frame(mk_frame(1000), 1'b1, "bp");
    wait_drain(1'b1, 1000, "bp");
    check("bp_beats", beat_cnt, 32);

    // double buffering: second pulse five cycles after the first
    beat_cnt = 0;
    bus_if.out_ready = 1'b1;
    send_frame(mk_frame(2000), 1'b1, "db1");
    repeat (3) @(posedge clk);
    send_frame(mk_frame(3000), 1'b1, "db2");
    check("db_both_full_ready", bus_if.frame_ready, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("db_mid_ready", bus_if.frame_ready, 1'b0);
    wait_drain(1'b0, 300, "db");
    check("db_beats", beat_cnt, 64);
    check("db_no_gap_in_frame", beat_t[31] - beat_t[0], 31);
    check("db_one_bubble", beat_t[32] - beat_t[31], 2);
    check("db_ready_after", bus_if.frame_ready, 1'b1);
    check("db_overflow", bus_if.overflow, 1'b0);

    // overflow: third frame dropped while both banks hold data
    beat_cnt = 0;
    bus_if.out_ready = 1'b0;
    send_frame(mk_frame(4000), 1'b1, "ov1");
    send_frame(mk_frame(5000), 1'b1, "ov2");
    send_frame(mk_frame(6000), 1'b0, "ov3");
    @(negedge clk);
    check("ov_set", bus_if.overflow, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("ov_sticky", bus_if.overflow, 1'b1);
    check("ov_stalled_valid", bus_if.out_valid, 1'b1);
    bus_if.out_ready = 1'b1;
    wait_drain(1'b0, 300, "ov");
    check("ov_beats", beat_cnt, 64);
    check("ov_sticky_end", bus_if.overflow, 1'b1);

    // reset in the middle of a frame discards it
    beat_cnt = 0;
    bus_if.out_ready = 1'b0;
    send_frame(mk_frame(7000), 1'b1, "mr");
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mr_out_valid", bus_if.out_valid, 1'b0);
    check("mr_frame_ready", bus_if.frame_ready, 1'b1);
    check("mr_overflow_clr", bus_if.overflow, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    bus_if.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("mr_no_beats", beat_cnt, 0);
    check("mr_idle_valid", bus_if.out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
